// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
//
// Purpose:
//   Drives a time-multiplexed 7-segment display from the BCD time digits of the
//   clock counters. One digit is lit per scan slot. The first BLANK_CYCLES of
//   every slot keep all digits dark so the previous digit's segments never
//   ghost onto the next one. Leading zeros can be suppressed. The inputs are
//   snapshotted once per frame, so a counter rollover mid-scan can never show
//   a frame that mixes old and new digits.
//
// Ports:
//   clk         in   1             system clock
//   reset       in   1             synchronous reset, active-high
//   digits_in   in   4*NUM_DIGITS  BCD digits; digit i = digits_in[4i+3:4i]
//   dp_in       in   NUM_DIGITS    decimal point request per digit
//   blank_zero  in   1             1: suppress leading zeros
//   seg_out     out  7             segments {g,f,e,d,c,b,a}
//   dp_out      out  1             decimal point of the lit digit
//   dig_sel     out  NUM_DIGITS    one-hot digit enable
//   frame_tick  out  1             one-cycle pulse after the last cycle of a frame
//
// All outputs are registered. The value in cycle n+1 reflects the scan
// position and the snapshot of cycle n.
// -----------------------------------------------------------------------------
module bcd_display_scanner #(
   parameter int NUM_DIGITS     = 6,
   parameter int SCAN_DIV       = 50000,
   parameter int BLANK_CYCLES   = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_zero,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    frame_tick
);

   localparam int DIV_W = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);

   // Polarity masks: the internal datapath is active-high, XOR at the register input.
   localparam logic [6:0]            SEG_POL = {7{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] DIG_POL = {NUM_DIGITS{DIG_ACTIVE_LOW}};

   // Active-high 7-segment decode, {g,f,e,d,c,b,a}. Non-BCD nibbles show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
      logic [6:0] seg;
      case (bcd)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = 7'h40;
      endcase
      return seg;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [DIV_W-1:0]                div_q, div_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0]      snap_digits_q, snap_digits_d;
   logic [NUM_DIGITS-1:0]           snap_dp_q, snap_dp_d;
   logic                            snap_bz_q, snap_bz_d;

   logic [6:0]                      seg_q, seg_d;
   logic                            dp_q, dp_d;
   logic [NUM_DIGITS-1:0]           dig_q, dig_d;
   logic                            tick_q, tick_d;

   // ---------------------------------------------------------------------------
   // Scan counters and per-frame snapshot
   // ---------------------------------------------------------------------------
   logic frame_start;
   assign frame_start = (div_q == '0) && (idx_q == '0);

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      div_d         = div_q;
      idx_d         = idx_q;
      snap_digits_d = snap_digits_q;
      snap_dp_d     = snap_dp_q;
      snap_bz_d     = snap_bz_q;

      if (div_q == DIV_LAST) begin
         div_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
         div_d = div_q + DIV_W'(1);
      end

      // The display shows only these registers, so a change on digits_in
      // part-way through a frame stays invisible until the next frame.
      if (frame_start) begin
         snap_digits_d = digits_in;
         snap_dp_d     = dp_in;
         snap_bz_d     = blank_zero;
      end
   end

   // ---------------------------------------------------------------------------
   // Leading-zero suppression mask
   // Walk from the most significant digit downwards. A digit is blanked while it
   // and every digit above it are zero. Digit 0 is never blanked, so "0" still
   // shows when the whole value is zero.
   // ---------------------------------------------------------------------------
   logic [NUM_DIGITS-1:0] lz_blank;

   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      lz_blank   = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above  = zero_above && (snap_digits_q[i] == 4'd0);
         lz_blank[i] = snap_bz_q && zero_above;
      end
   end

   // ---------------------------------------------------------------------------
   // Digit select for the current slot
   // An explicit compare loop is used rather than a variable index, so an idx
   // value that cannot be reached never produces an out-of-range select.
   // ---------------------------------------------------------------------------
   logic [3:0]            cur_digit;
   logic                  cur_dp;
   logic                  cur_blank;
   logic [NUM_DIGITS-1:0] dig_onehot;

   always_comb begin
      cur_digit  = 4'd0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b0;
      dig_onehot = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_digit     = snap_digits_q[i];
            cur_dp        = snap_dp_q[i];
            cur_blank     = lz_blank[i];
            dig_onehot[i] = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output next-state
   // The slot stays dark during its first BLANK_CYCLES. A suppressed leading
   // zero keeps its digit enabled and its decimal point. Only the segments go
   // dark, so the brightness of the lit digits stays the same.
   // ---------------------------------------------------------------------------
   logic       lit;
   logic [6:0] seg_act;

   always_comb begin
      lit     = (div_q >= BLANK_END);
      seg_act = (lit && !cur_blank) ? seg_decode(cur_digit) : 7'h00;
      seg_d   = seg_act ^ SEG_POL;
      dp_d    = (lit && cur_dp) ^ SEG_ACTIVE_LOW;
      dig_d   = (lit ? dig_onehot : '0) ^ DIG_POL;
      tick_d  = (idx_q == IDX_LAST) && (div_q == DIV_LAST);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments, so every register
      // samples the values from before the edge and register order does not matter.
      if (reset) begin
         div_q         <= '0;
         idx_q         <= '0;
         // NOTE: the snapshot is a handful of flops, not a RAM. Clearing it on
         // reset is cheap and keeps the first frame deterministic.
         snap_digits_q <= '0;
         snap_dp_q     <= '0;
         snap_bz_q     <= 1'b0;
         seg_q         <= SEG_POL;
         dp_q          <= SEG_ACTIVE_LOW;
         dig_q         <= DIG_POL;
         tick_q        <= 1'b0;
      end else begin
         div_q         <= div_d;
         idx_q         <= idx_d;
         snap_digits_q <= snap_digits_d;
         snap_dp_q     <= snap_dp_d;
         snap_bz_q     <= snap_bz_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         dig_q         <= dig_d;
         tick_q        <= tick_d;
      end
   end

   assign seg_out    = seg_q;
   assign dp_out     = dp_q;
   assign dig_sel    = dig_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_scanner
//
// Purpose:
//   Self-checking bench for bcd_display_scanner with NUM_DIGITS=6, SCAN_DIV=8,
//   BLANK_CYCLES=2 and both polarities active-low.
//
//   A reference model runs on the falling edge. It predicts what the DUT will
//   output after the next rising edge and pushes that prediction into a
//   scoreboard queue. On the following falling edge the prediction is popped
//   and compared with the DUT outputs.
//
//   The main initial block drives the directed steps (reset, normal scan,
//   leading-zero suppression, dash decode, mid-frame change, mid-frame reset).
//   It also checks hand-derived constants at chosen edges.
// -----------------------------------------------------------------------------
module tb_bcd_display_scanner;

   localparam int ND = 6;
   localparam int SD = 8;
   localparam int BC = 2;

   logic          clk        = 1'b0;
   logic          reset      = 1'b1;
   logic [4*ND-1:0] digits_in = '0;
   logic [ND-1:0] dp_in      = '0;
   logic          blank_zero = 1'b0;
   logic [6:0]    seg_out;
   logic          dp_out;
   logic [ND-1:0] dig_sel;
   logic          frame_tick;

   always #5 clk = ~clk;

   bcd_display_scanner #(
      .NUM_DIGITS     (ND),
      .SCAN_DIV       (SD),
      .BLANK_CYCLES   (BC),
      .SEG_ACTIVE_LOW (1'b1),
      .DIG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .blank_zero (blank_zero),
      .seg_out    (seg_out),
      .dp_out     (dp_out),
      .dig_sel    (dig_sel),
      .frame_tick (frame_tick)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [6:0] seg, input logic dp,
                            input logic [ND-1:0] dig, input logic ft);
      check({tag, ".seg"}, 32'(seg_out),    32'(seg));
      check({tag, ".dp"},  32'(dp_out),     32'(dp));
      check({tag, ".dig"}, 32'(dig_sel),    32'(dig));
      check({tag, ".ft"},  32'(frame_tick), 32'(ft));
   endtask

   // ---------------------------------------------------------------------------
   // Reference model + scoreboard
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [6:0]    seg;
      logic          dp;
      logic [ND-1:0] dig;
      logic          ft;
   } exp_t;

   exp_t sb_q[$];

   function automatic logic [6:0] ref_seg(input logic [3:0] n);
      case (n)
         4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
         4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
         4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
         4'd9: return 7'h6F;  default: return 7'h40;
      endcase
   endfunction

   int            m_div = 0;
   int            m_idx = 0;
   logic [3:0]    m_dig [ND];
   logic [ND-1:0] m_dp  = '0;
   logic          m_bz  = 1'b0;

   initial for (int i = 0; i < ND; i++) m_dig[i] = 4'd0;

   always @(negedge clk) begin
      exp_t x;
      int   msnz;
      logic lit;
      logic blanked;

      if (sb_q.size() != 0) begin
         x = sb_q.pop_front();
         check("sb.seg", 32'(seg_out),    32'(x.seg));
         check("sb.dp",  32'(dp_out),     32'(x.dp));
         check("sb.dig", 32'(dig_sel),    32'(x.dig));
         check("sb.ft",  32'(frame_tick), 32'(x.ft));
      end

      if (reset) begin
         x.seg = 7'h7F;
         x.dp  = 1'b1;
         x.dig = '1;
         x.ft  = 1'b0;
         m_div = 0;
         m_idx = 0;
         m_dp  = '0;
         m_bz  = 1'b0;
         for (int i = 0; i < ND; i++) m_dig[i] = 4'd0;
      end else begin
         // Most significant non-zero digit. Every digit above it is a leading zero.
         msnz = 0;
         for (int i = 0; i < ND; i++) if (m_dig[i] != 4'd0) msnz = i;
         lit     = (m_div >= BC);
         blanked = m_bz && (m_idx > msnz);
         x.seg = ~((lit && !blanked) ? ref_seg(m_dig[m_idx]) : 7'h00);
         x.dp  = ~(lit && m_dp[m_idx]);
         x.dig = lit ? ~(ND'(1) << m_idx) : '1;
         x.ft  = (m_idx == ND - 1) && (m_div == SD - 1);

         if (m_div == 0 && m_idx == 0) begin
            for (int i = 0; i < ND; i++) m_dig[i] = digits_in[4*i +: 4];
            m_dp = dp_in;
            m_bz = blank_zero;
         end
         if (m_div == SD - 1) begin
            m_div = 0;
            m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
         end else begin
            m_div = m_div + 1;
         end
      end
      sb_q.push_back(x);
   end

   // ---------------------------------------------------------------------------
   // Directed sequence. Edge Ek is the k-th rising edge after reset release.
   // Edge E0 is the first scan cycle, and it captures the snapshot.
   // ---------------------------------------------------------------------------
   int e;

   task automatic to_edge(input int t);
      repeat (t - e) @(posedge clk);
      e = t;
      #2;
   endtask

   initial begin
      // 1. reset held for three cycles
      repeat (3) begin
         @(posedge clk);
         #2;
         check_out("reset_hold", 7'h7F, 1'b1, 6'h3F, 1'b0);
      end

      // 2. 23:59:59, no suppression
      digits_in  = 24'h235959;
      dp_in      = 6'h00;
      blank_zero = 1'b0;
      reset      = 1'b0;
      e          = -1;
      to_edge(1);  check_out("t2_blank", 7'h7F, 1'b1, 6'h3F, 1'b0);
      to_edge(2);  check_out("t2_slot0", 7'h10, 1'b1, 6'h3E, 1'b0);
      to_edge(42); check_out("t2_slot5", 7'h24, 1'b1, 6'h1F, 1'b0);
      to_edge(46); check("t2_ft_pre",  32'(frame_tick), 32'd0);
      to_edge(47); check("t2_ft",      32'(frame_tick), 32'd1);

      // 3. 00:01:05 with leading-zero suppression; dp requested on blanked digit 3
      digits_in  = 24'h000105;
      dp_in      = 6'b001000;
      blank_zero = 1'b1;
      to_edge(48); check("t3_ft_post", 32'(frame_tick), 32'd0);
      to_edge(50); check_out("t3_d0", 7'h12, 1'b1, 6'h3E, 1'b0);
      to_edge(58); check_out("t3_d1", 7'h40, 1'b1, 6'h3D, 1'b0);
      to_edge(74); check_out("t3_d3", 7'h7F, 1'b0, 6'h37, 1'b0);
      to_edge(90); check_out("t3_d5", 7'h7F, 1'b1, 6'h1F, 1'b0);

      // 4. non-BCD nibble shows a dash
      digits_in  = 24'h12345A;
      dp_in      = 6'h00;
      blank_zero = 1'b0;
      to_edge(95); check("t3_ft2", 32'(frame_tick), 32'd1);
      to_edge(98); check_out("t4_dash", 7'h3F, 1'b1, 6'h3E, 1'b0);

      // 5. inputs change during slot 2; the rest of the frame keeps old values
      to_edge(114); check_out("t5_d2_old", 7'h19, 1'b1, 6'h3B, 1'b0);
      digits_in = 24'h987650;
      to_edge(115); check_out("t5_d2_hold", 7'h19, 1'b1, 6'h3B, 1'b0);
      to_edge(138); check_out("t5_d5_hold", 7'h79, 1'b1, 6'h1F, 1'b0);
      to_edge(146); check_out("t5_d0_new",  7'h40, 1'b1, 6'h3E, 1'b0);
      to_edge(162); check_out("t5_d2_new",  7'h02, 1'b1, 6'h3B, 1'b0);

      // 6. reset raised at idx=3, div=5
      to_edge(172); check_out("t6_pre", 7'h78, 1'b1, 6'h37, 1'b0);
      reset = 1'b1;
      to_edge(173); check_out("t6_rst", 7'h7F, 1'b1, 6'h3F, 1'b0);
      reset = 1'b0;
      e     = -1;
      to_edge(1);  check_out("t6_blank", 7'h7F, 1'b1, 6'h3F, 1'b0);
      to_edge(2);  check_out("t6_slot0", 7'h40, 1'b1, 6'h3E, 1'b0);
      to_edge(47); check("t6_ft", 32'(frame_tick), 32'd1);
      to_edge(50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
